// File: rtl/hydra_pkg.sv
// rtl/hydra_pkg.sv - shared hydra switch types and constants
package hydra_pkg;

    localparam int PORT_NUM = 16;
    localparam int DATA_W   = 16;
    localparam int LEN_W    = 9;
    localparam int DEST_W   = $clog2(PORT_NUM);

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [2:0]        prio;
        logic [DEST_W-1:0] dest;
    } hdr_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DEST  = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_PROTO = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_SOP,
        S_HDR,
        S_PAYLOAD,
        S_DISCARD,
        S_CLOSE
    } rx_state_t;

endpackage

// File: rtl/egress_sram.sv
// rtl/egress_sram.sv - simple dual-port RAM, one write port, registered read port
module egress_sram #(
    parameter int AW = 10,
    parameter int W  = 17
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    // rdata holds its value when re is low; the egress prefetch relies on it
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/egress_port.sv
// rtl/egress_port.sv - per-port egress sink: header/length check, store-and-forward replay
module egress_port
    import hydra_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int DEPTH     = 1024,
    parameter int MAX_WORDS = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              ready,
    input  logic              rd_sop,
    input  logic              rd_vld,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       err_cnt,
    output logic              err_pulse,
    output logic [1:0]        err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]       DEPTH_P   = DEPTH[AW:0];
    localparam logic [AW:0]       MAX_P     = MAX_WORDS[AW:0];
    localparam int                PAY_MAX_I = MAX_WORDS - 1;
    localparam logic [LEN_W:0]    PAY_MAX   = PAY_MAX_I[LEN_W:0];
    localparam logic [DEST_W-1:0] MY_ID     = PORT_ID[DEST_W-1:0];

    rx_state_t          state, state_n;
    logic [AW:0]        wr_ptr, rd_ptr, commit_ptr, free_space;
    logic [DATA_W-1:0]  pend_data;
    logic [LEN_W-1:0]   hdr_len;
    logic [LEN_W:0]     pay_cnt;
    err_code_t          drop_code, flag_drop, close_code;
    logic               take_hdr, take_pay, eop_seen, commit, drop;
    hdr_t               hdr_in;
    logic               ram_we, rd_pend, sop_next, avail, advance, issue;
    logic [DATA_W:0]    ram_rdata;

    assign hdr_in     = hdr_t'(rd_data);
    assign free_space = DEPTH_P - (wr_ptr - rd_ptr);

    always_comb begin
        state_n   = state;
        flag_drop = ERR_NONE;
        take_hdr  = 1'b0;
        take_pay  = 1'b0;
        eop_seen  = 1'b0;
        case (state)
            S_IDLE:     if (enable && free_space >= MAX_P) state_n = S_REQ;
            S_REQ:      state_n = S_WAIT_SOP;
            S_WAIT_SOP: if (rd_sop) state_n = S_HDR;
            S_HDR: begin
                if (rd_sop || rd_eop) begin
                    flag_drop = ERR_PROTO;
                    eop_seen  = rd_eop;
                    state_n   = rd_eop ? S_CLOSE : S_DISCARD;
                end else if (rd_vld) begin
                    if (hdr_in.dest != MY_ID) begin
                        flag_drop = ERR_DEST;
                        state_n   = S_DISCARD;
                    end else begin
                        take_hdr = 1'b1;
                        state_n  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rd_eop) begin
                    eop_seen = 1'b1;
                    state_n  = S_CLOSE;
                    if (rd_sop)                             flag_drop = ERR_PROTO;
                    else if (pay_cnt != {1'b0, hdr_len})    flag_drop = ERR_LEN;
                end else if (rd_sop) begin
                    flag_drop = ERR_PROTO;
                    state_n   = S_DISCARD;
                end else if (rd_vld) begin
                    if (pay_cnt == PAY_MAX) begin
                        flag_drop = ERR_PROTO;
                        state_n   = S_DISCARD;
                    end else begin
                        take_pay = 1'b1;
                    end
                end
            end
            S_DISCARD: if (rd_eop) begin
                eop_seen = 1'b1;
                state_n  = S_CLOSE;
            end
            S_CLOSE:    state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    assign close_code = (state == S_DISCARD) ? drop_code : flag_drop;
    assign commit     = eop_seen && (close_code == ERR_NONE);
    assign drop       = eop_seen && (close_code != ERR_NONE);
    // one word is held back so the last-flag can be attached once rd_eop arrives
    assign ram_we     = take_pay || commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            ready      <= 1'b0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pend_data  <= '0;
            hdr_len    <= '0;
            pay_cnt    <= '0;
            drop_code  <= ERR_NONE;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
            err_pulse  <= 1'b0;
            err_code   <= 2'd0;
        end else begin
            state     <= state_n;
            ready     <= (state_n == S_REQ);
            err_pulse <= drop;
            if (eop_seen)                    drop_code <= ERR_NONE;
            else if (flag_drop != ERR_NONE)  drop_code <= flag_drop;
            if (take_hdr) begin
                pend_data <= hdr_in;
                hdr_len   <= hdr_in.len;
                pay_cnt   <= '0;
            end
            if (take_pay) begin
                pend_data <= rd_data;
                pay_cnt   <= pay_cnt + 1'b1;
            end
            if (ram_we) wr_ptr <= wr_ptr + 1'b1;
            if (commit) begin
                commit_ptr <= wr_ptr + 1'b1;
                if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (drop) begin
                wr_ptr   <= commit_ptr;
                err_code <= close_code;
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
        end
    end

    egress_sram #(.AW(AW), .W(DATA_W + 1)) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({commit, pend_data}),
        .re    (issue),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (ram_rdata)
    );

    // rd_pend marks a word sitting in the RAM read register, ahead of the output register
    assign avail   = (rd_ptr != commit_ptr);
    assign advance = rd_pend && (!out_valid || out_ready);
    assign issue   = avail && (!rd_pend || advance);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            rd_pend   <= 1'b0;
            sop_next  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else begin
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            rd_pend <= issue || (rd_pend && !advance);
            if (advance) begin
                out_valid <= 1'b1;
                out_data  <= ram_rdata[DATA_W-1:0];
                out_eop   <= ram_rdata[DATA_W];
                out_sop   <= sop_next;
                sop_next  <= ram_rdata[DATA_W];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
